// File: rtl/mem_port_arbiter.sv
// Purpose : shares one fixed-latency, line-wide memory port between the I-cache and
//           D-cache miss paths; latches one request per transaction and returns the line.
// Latency : read acks LATENCY cycles after the grant edge, write+read 2*LATENCY, write-only LATENCY.
// Backpressure: requests are levels held until ack; they are ignored while busy.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   i_req_read, i_address                I-cache line read request and address
//   i_rdata, i_ack                       registered I line, one-cycle I completion pulse
//   d_req_read, d_req_write              D-cache refill / writeback requests
//   d_address, d_wb_address, d_wdata     D refill address, writeback address and line
//   d_rdata, d_ack                       registered D line, one-cycle D completion pulse
//   m_read, m_write, m_address           memory strobes and line-aligned address
//   m_wdata, m_rdata                     memory write line (0 when idle), memory read line
//   busy                                 high whenever a transaction is in flight
module mem_port_arbiter #(
   parameter int WORD_SIZE    = 16,
   parameter int LINE_SIZE    = 64,
   parameter int LATENCY      = 4,
   parameter int MAX_D_STREAK = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req_read,
   input  logic [WORD_SIZE-1:0] i_address,
   output logic [LINE_SIZE-1:0] i_rdata,
   output logic                 i_ack,
   input  logic                 d_req_read,
   input  logic                 d_req_write,
   input  logic [WORD_SIZE-1:0] d_address,
   input  logic [WORD_SIZE-1:0] d_wb_address,
   input  logic [LINE_SIZE-1:0] d_wdata,
   output logic [LINE_SIZE-1:0] d_rdata,
   output logic                 d_ack,
   output logic                 m_read,
   output logic                 m_write,
   output logic [WORD_SIZE-1:0] m_address,
   output logic [LINE_SIZE-1:0] m_wdata,
   input  logic [LINE_SIZE-1:0] m_rdata,
   output logic                 busy
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
   localparam logic [CW-1:0]        CNT_INIT   = CW'(LATENCY - 1);
   localparam logic [SW-1:0]        STREAK_MAX = SW'(MAX_D_STREAK);
   // Lines are 4 words, so the low two address bits never reach memory.
   localparam logic [WORD_SIZE-1:0] LINE_MASK  = ~WORD_SIZE'(3);

   typedef enum logic [1:0] {IDLE, BUSY_W, BUSY_R, ACK} state_t;

   state_t                 r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic [SW-1:0]          r_d_streak;
   logic                   r_is_d;
   logic                   r_rd;
   logic [WORD_SIZE-1:0]   r_addr;
   logic [WORD_SIZE-1:0]   r_wb_addr;
   logic [LINE_SIZE-1:0]   r_wdata;

   logic w_d_req, w_i_force, w_grant_i, w_grant_d, w_grant, w_capture;

   // D has priority unless it has already won MAX_D_STREAK times in a row while I waited.
   assign w_d_req   = d_req_read | d_req_write;
   assign w_i_force = i_req_read && (r_d_streak == STREAK_MAX);
   assign w_grant_i = i_req_read && (!w_d_req || w_i_force);
   assign w_grant_d = w_d_req && !w_grant_i;
   assign w_grant   = (r_state == IDLE) && (w_grant_i || w_grant_d);
   assign w_capture = (r_state == BUSY_R) && (r_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_address   = '0;
      m_wdata     = '0;
      i_ack       = 1'b0;
      d_ack       = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_grant_i) begin
               w_state_nxt = BUSY_R;
               w_cnt_nxt   = CNT_INIT;
            end else if (w_grant_d) begin
               // A writeback always goes first; any refill follows it.
               w_state_nxt = d_req_write ? BUSY_W : BUSY_R;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         BUSY_W: begin
            m_write   = 1'b1;
            m_address = r_wb_addr & LINE_MASK;
            m_wdata   = r_wdata;
            if (r_cnt == '0) begin
               if (r_rd) begin
                  w_state_nxt = BUSY_R;
                  w_cnt_nxt   = CNT_INIT;
               end else begin
                  w_state_nxt = ACK;
               end
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         BUSY_R: begin
            m_read    = 1'b1;
            m_address = r_addr & LINE_MASK;
            if (r_cnt == '0) w_state_nxt = ACK;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         ACK: begin
            i_ack       = !r_is_d;
            d_ack       = r_is_d;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_d_streak <= '0;
         r_is_d     <= 1'b0;
         r_rd       <= 1'b0;
         r_addr     <= '0;
         r_wb_addr  <= '0;
         r_wdata    <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         if (w_grant) begin
            r_is_d <= w_grant_d;
            r_rd   <= w_grant_i | d_req_read;
            r_addr <= w_grant_i ? i_address : d_address;
            if (w_grant_d && d_req_write) begin
               r_wb_addr <= d_wb_address;
               r_wdata   <= d_wdata;
            end
            // Streak only grows while I is actually being passed over.
            if (w_grant_i || !i_req_read)
               r_d_streak <= '0;
            else if (r_d_streak != STREAK_MAX)
               r_d_streak <= r_d_streak + SW'(1);
         end
         // m_rdata is only valid in the final read cycle.
         if (w_capture) begin
            if (r_is_d) d_rdata <= m_rdata;
            else        i_rdata <= m_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a fixed-latency memory model.
// Latency : memory line is presented only in the final m_read cycle of each burst.
// Backpressure: requesters hold req until they see their ack, then drop it.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        i_req_read;
   logic [15:0] i_address;
   logic [63:0] i_rdata;
   logic        i_ack;
   logic        d_req_read;
   logic        d_req_write;
   logic [15:0] d_address;
   logic [15:0] d_wb_address;
   logic [63:0] d_wdata;
   logic [63:0] d_rdata;
   logic        d_ack;
   logic        m_read;
   logic        m_write;
   logic [15:0] m_address;
   logic [63:0] m_wdata;
   logic [63:0] m_rdata;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter #(
      .WORD_SIZE(16), .LINE_SIZE(64), .LATENCY(4), .MAX_D_STREAK(2)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req_read(i_req_read), .i_address(i_address), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req_read(d_req_read), .d_req_write(d_req_write), .d_address(d_address),
      .d_wb_address(d_wb_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] line_of(input logic [15:0] a);
      return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
   endfunction

   // Memory model: the real line appears only in the 4th consecutive read cycle.
   logic [2:0] rcnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)    rcnt <= '0;
      else if (m_read) rcnt <= rcnt + 3'd1;
      else             rcnt <= '0;
   end
   assign m_rdata = (m_read && rcnt == 3'd3) ? line_of(m_address) : 64'hBAD0_BAD0_BAD0_BAD0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   int          n_rd, n_wr, n_busy, n_iack, n_dack, i_ack_at, d_ack_at, first_rd_at;
   logic [15:0] rd_addr, wr_addr;
   logic [63:0] wr_data;
   logic        wdata_leak;

   // Watches n edges (k=0 is the first edge after the call) and drops requests on ack.
   task automatic observe(input int n);
      n_rd = 0; n_wr = 0; n_busy = 0; n_iack = 0; n_dack = 0;
      i_ack_at = -1; d_ack_at = -1; first_rd_at = -1;
      rd_addr = '0; wr_addr = '0; wr_data = '0; wdata_leak = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (m_read) begin
            n_rd++;
            rd_addr = m_address;
            if (first_rd_at < 0) first_rd_at = k;
         end
         if (m_write) begin
            n_wr++;
            wr_addr = m_address;
            wr_data = m_wdata;
         end else if (m_wdata != 64'd0) begin
            wdata_leak = 1'b1;
         end
         if (busy) n_busy++;
         if (i_ack) begin
            n_iack++;
            if (i_ack_at < 0) i_ack_at = k;
            i_req_read = 1'b0;
         end
         if (d_ack) begin
            n_dack++;
            if (d_ack_at < 0) d_ack_at = k;
            d_req_read  = 1'b0;
            d_req_write = 1'b0;
         end
      end
   endtask

   logic [5:0] order;
   int         nacks;

   initial begin
      reset_n = 1'b0;
      i_req_read = 1'b0; i_address = '0;
      d_req_read = 1'b0; d_req_write = 1'b0;
      d_address = '0; d_wb_address = '0; d_wdata = '0;

      // Reset state
      #12;
      chk("rst_busy",   64'(busy),    64'd0);
      chk("rst_m_read", 64'(m_read),  64'd0);
      chk("rst_m_wr",   64'(m_write), 64'd0);
      chk("rst_m_addr", 64'(m_address), 64'd0);
      chk("rst_acks",   64'({i_ack, d_ack}), 64'd0);
      chk("rst_i_rd",   i_rdata, 64'd0);
      chk("rst_d_rd",   d_rdata, 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: single I read, unaligned address
      i_req_read = 1'b1; i_address = 16'h0025;
      observe(8);
      chk("t1_nrd",    64'(n_rd),     64'd4);
      chk("t1_raddr",  64'(rd_addr),  64'h0024);
      chk("t1_ackat",  64'(i_ack_at), 64'd4);
      chk("t1_niack",  64'(n_iack),   64'd1);
      chk("t1_ndack",  64'(n_dack),   64'd0);
      chk("t1_irdata", i_rdata, line_of(16'h0024));
      chk("t1_drdata", d_rdata, 64'd0);

      // 2: I and D read together -> D first, then I
      i_req_read = 1'b1; i_address = 16'h0101;
      d_req_read = 1'b1; d_address = 16'h0202;
      observe(14);
      chk("t2_dackat", 64'(d_ack_at), 64'd4);
      chk("t2_iackat", 64'(i_ack_at), 64'd10);
      chk("t2_nrd",    64'(n_rd),     64'd8);
      chk("t2_drdata", d_rdata, line_of(16'h0200));
      chk("t2_irdata", i_rdata, line_of(16'h0100));

      // 3: D write+read
      d_req_read = 1'b1; d_req_write = 1'b1;
      d_wb_address = 16'h0040; d_wdata = 64'h0001_0002_0003_0004; d_address = 16'h0010;
      observe(12);
      chk("t3_nwr",    64'(n_wr),        64'd4);
      chk("t3_waddr",  64'(wr_addr),     64'h0040);
      chk("t3_wdata",  wr_data,          64'h0001_0002_0003_0004);
      chk("t3_nrd",    64'(n_rd),        64'd4);
      chk("t3_rdat",   64'(first_rd_at), 64'd4);
      chk("t3_raddr",  64'(rd_addr),     64'h0010);
      chk("t3_dackat", 64'(d_ack_at),    64'd8);
      chk("t3_ndack",  64'(n_dack),      64'd1);
      chk("t3_leak",   64'(wdata_leak),  64'd0);
      chk("t3_drdata", d_rdata, line_of(16'h0010));
      chk("t3_irdata", i_rdata, line_of(16'h0100));

      // 4: starvation limit with both sides requesting continuously
      i_req_read = 1'b1; i_address = 16'h0300;
      d_req_read = 1'b1; d_address = 16'h0400;
      order = '0; nacks = 0;
      for (int k = 0; k < 60 && nacks < 6; k++) begin
         @(posedge clk); #1;
         if (i_ack || d_ack) begin
            order = {order[4:0], d_ack};
            nacks++;
         end
      end
      i_req_read = 1'b0; d_req_read = 1'b0;
      chk("t4_nacks", 64'(nacks), 64'd6);
      chk("t4_order", 64'(order), 64'(6'b110110));
      chk("t4_irdata", i_rdata, line_of(16'h0300));
      chk("t4_drdata", d_rdata, line_of(16'h0400));
      repeat (2) @(posedge clk);
      #1;

      // 5: reset in the 2nd read cycle aborts without ack
      i_req_read = 1'b1; i_address = 16'h0500;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_pre_rd", 64'(m_read), 64'd1);
      #2;
      reset_n = 1'b0; i_req_read = 1'b0;
      #1;
      chk("t5_m_read", 64'(m_read), 64'd0);
      chk("t5_busy",   64'(busy),   64'd0);
      chk("t5_irdata", i_rdata,     64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      observe(6);
      chk("t5_noack",  64'(n_iack + n_dack), 64'd0);
      chk("t5_idle",   64'(n_busy), 64'd0);
      i_req_read = 1'b1; i_address = 16'h0500;
      observe(8);
      chk("t5_ackat",  64'(i_ack_at), 64'd4);
      chk("t5_irdata2", i_rdata, line_of(16'h0500));

      // 6: empty D request, then a refill, then write-only
      observe(4);
      chk("t6_noreq", 64'(n_busy), 64'd0);
      d_req_read = 1'b1; d_address = 16'h0600;
      observe(8);
      chk("t6_drdata0", d_rdata, line_of(16'h0600));
      d_req_write = 1'b1; d_wb_address = 16'h0707; d_wdata = 64'hAAAA_5555_1234_8765;
      observe(8);
      chk("t6_nrd",    64'(n_rd),       64'd0);
      chk("t6_nwr",    64'(n_wr),       64'd4);
      chk("t6_waddr",  64'(wr_addr),    64'h0704);
      chk("t6_wdata",  wr_data,         64'hAAAA_5555_1234_8765);
      chk("t6_dackat", 64'(d_ack_at),   64'd4);
      chk("t6_ndack",  64'(n_dack),     64'd1);
      chk("t6_leak",   64'(wdata_leak), 64'd0);
      chk("t6_drdata", d_rdata, line_of(16'h0600));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
